// File: rtl/led_fader_if.sv
// led_fader bus: per-channel LED requests in,
// PWM pins and settle flags out.
interface led_fader_if;
  logic [7:0] req;
  logic [7:0] led_out;
  logic [7:0] at_full;
  logic [7:0] at_off;

  modport master (
    output req,
    input  led_out,
    input  at_full,
    input  at_off
  );

  modport slave (
    input  req,
    output led_out,
    output at_full,
    output at_off
  );
endinterface

// File: rtl/led_fader.sv
// led_fader: eight-channel PWM fader.
// Duty ramps toward the requested level one step per tick.
module led_fader #(
  parameter int unsigned STEP_DIV = 1024,
  parameter int unsigned MAX_DUTY = 255
) (
  input  logic       hwclk,
  input  logic       rst,
  led_fader_if.slave bus
);

  localparam int unsigned DW =
    (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(STEP_DIV - 1);
  localparam logic [7:0] DMAX = 8'(MAX_DUTY);

  typedef enum logic [1:0] {
    IDLE, RISE, FULL, FALL
  } st_e;

  logic [7:0]    pwm_q, pwm_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick;

  st_e        st_q   [8];
  st_e        st_d   [8];
  logic [7:0] duty_q [8];
  logic [7:0] duty_d [8];

  logic [7:0] led_q, led_d;
  logic [7:0] full_q, full_d;
  logic [7:0] off_q, off_d;

  // Free-running PWM counter and step prescaler.
  always_comb begin
    pwm_d = pwm_q + 8'd1;
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Per-channel state and duty; a req change
  // decides the direction of a same-cycle step.
  always_comb begin
    led_d  = '0;
    full_d = '0;
    off_d  = '0;
    for (int i = 0; i < 8; i++) begin
      st_d[i]   = st_q[i];
      duty_d[i] = duty_q[i];
      unique case (st_q[i])
        IDLE: if (bus.req[i])  st_d[i] = RISE;
        RISE: if (!bus.req[i]) st_d[i] = FALL;
        FULL: if (!bus.req[i]) st_d[i] = FALL;
        FALL: if (bus.req[i])  st_d[i] = RISE;
        default: st_d[i] = IDLE;
      endcase
      if (tick) begin
        if (st_d[i] == RISE) begin
          if (duty_q[i] < DMAX)
            duty_d[i] = duty_q[i] + 8'd1;
          if (duty_d[i] == DMAX)
            st_d[i] = FULL;
        end else if (st_d[i] == FALL) begin
          if (duty_q[i] != 8'd0)
            duty_d[i] = duty_q[i] - 8'd1;
          if (duty_d[i] == 8'd0)
            st_d[i] = IDLE;
        end
      end
      led_d[i]  = (duty_q[i] > pwm_q);
      full_d[i] = (st_d[i] == FULL);
      off_d[i]  = (st_d[i] == IDLE);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      pwm_q  <= '0;
      div_q  <= '0;
      led_q  <= '0;
      full_q <= '0;
      off_q  <= '1;
      for (int i = 0; i < 8; i++) begin
        st_q[i]   <= IDLE;
        duty_q[i] <= '0;
      end
    end else begin
      pwm_q  <= pwm_d;
      div_q  <= div_d;
      led_q  <= led_d;
      full_q <= full_d;
      off_q  <= off_d;
      for (int i = 0; i < 8; i++) begin
        st_q[i]   <= st_d[i];
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign bus.led_out = led_q;
  assign bus.at_full = full_q;
  assign bus.at_off  = off_q;

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed bench with a cycle model
// scoreboard plus spec-derived timing checks.
module tb_led_fader;

  localparam int SD = 4;
  localparam int MD = 255;

  logic hwclk = 1'b0;
  logic rst;

  always #5 hwclk = ~hwclk;

  led_fader_if bus ();
  led_fader_if bus2 ();

  led_fader #(
    .STEP_DIV(SD),
    .MAX_DUTY(MD)
  ) dut (
    .hwclk(hwclk),
    .rst  (rst),
    .bus  (bus)
  );

  led_fader #(
    .STEP_DIV(4),
    .MAX_DUTY(128)
  ) dut2 (
    .hwclk(hwclk),
    .rst  (rst),
    .bus  (bus2)
  );

  int checks = 0;
  int errors = 0;

  int m_pwm = 0;
  int m_div = 0;
  int m_duty [8];
  int m_st   [8];
  logic [23:0] exp_q [$];
  bit saw_full;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [7:0] el, ef, eo;
    logic [23:0] e, got;
    bit tk, r;
    int ns, d;
    el = '0;
    ef = '0;
    eo = '0;
    tk = (m_div == SD - 1);
    if (rst) begin
      eo = 8'hFF;
      m_pwm = 0;
      m_div = 0;
      for (int i = 0; i < 8; i++) begin
        m_duty[i] = 0;
        m_st[i] = 0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        el[i] = (m_duty[i] > m_pwm);
        r = bus.req[i];
        case (m_st[i])
          0: ns = r ? 1 : 0;
          1: ns = r ? 1 : 3;
          2: ns = r ? 2 : 3;
          default: ns = r ? 1 : 3;
        endcase
        d = m_duty[i];
        if (tk && ns == 1) begin
          if (d < MD) d = d + 1;
          if (d == MD) ns = 2;
        end
        if (tk && ns == 3) begin
          if (d > 0) d = d - 1;
          if (d == 0) ns = 0;
        end
        m_duty[i] = d;
        m_st[i] = ns;
        ef[i] = (ns == 2);
        eo[i] = (ns == 0);
      end
      m_pwm = (m_pwm + 1) % 256;
      m_div = tk ? 0 : m_div + 1;
    end
    exp_q.push_back({el, ef, eo});
    @(posedge hwclk);
    #1;
    got = {bus.led_out, bus.at_full, bus.at_off};
    e = exp_q.pop_front();
    if (bus.at_full[0] === 1'b1) saw_full = 1'b1;
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL scoreboard t=%0t got=%h exp=%h",
             $time, got, e);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_bit(input bit off,
                          input int b,
                          input int bound,
                          output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      step();
      if ((off ? bus.at_off[b] : bus.at_full[b])
          === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic count_hi(input bit second,
                          input int b,
                          input int cyc,
                          output int c);
    c = 0;
    for (int k = 0; k < cyc; k++) begin
      step();
      if ((second ? bus2.led_out[b] : bus.led_out[b])
          === 1'b1) c++;
    end
  endtask

  initial begin
    int n, c;
    rst = 1'b1;
    bus.req = 8'h00;
    bus2.req = 8'h00;

    run(3);
    chk("rst_led", bus.led_out, 8'h00);
    chk("rst_full", bus.at_full, 8'h00);
    chk("rst_off", bus.at_off, 8'hFF);

    rst = 1'b0;
    run(2000);
    chk("idle_led", bus.led_out, 8'h00);
    chk("idle_full", bus.at_full, 8'h00);
    chk("idle_off", bus.at_off, 8'hFF);

    rst = 1'b1;
    run(1);
    rst = 1'b0;
    bus.req = 8'h01;
    step();
    chk("ramp_off0", bus.at_off, 8'hFE);
    wait_bit(1'b0, 0, 1100, n);
    chk("ramp_full_lat", n, 1019);
    count_hi(1'b0, 0, 256, c);
    chk("pwm255", c, 255);

    rst = 1'b1;
    run(1);
    rst = 1'b0;
    saw_full = 1'b0;
    run(160);
    bus.req = 8'h00;
    wait_bit(1'b1, 0, 400, n);
    chk("rev_fall_lat", n, 160);
    chk("rev_no_full", saw_full, 0);
    count_hi(1'b0, 0, 300, c);
    chk("rev_led_off", c, 0);

    rst = 1'b1;
    run(1);
    rst = 1'b0;
    bus.req = 8'h01;
    run(43);
    bus.req = 8'h00;
    wait_bit(1'b1, 0, 100, n);
    chk("tick_rev_lat", n, 37);

    rst = 1'b1;
    run(1);
    rst = 1'b0;
    bus.req = 8'hA5;
    bus2.req = 8'hA5;
    run(511);
    chk("mix_pre_full", bus2.at_full, 8'h00);
    step();
    chk("mix_full", bus2.at_full, 8'hA5);
    chk("mix_off", bus2.at_off, 8'h5A);
    chk("mix_off_d1", bus.at_off, 8'h5A);
    count_hi(1'b1, 7, 256, c);
    chk("pwm128", c, 128);
    count_hi(1'b1, 1, 256, c);
    chk("mix_idle_led", c, 0);

    bus.req = 8'h08;
    bus2.req = 8'h00;
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    wait_bit(1'b0, 3, 1100, n);
    chk("ch3_full_lat", n, 1020);
    rst = 1'b1;
    run(1);
    chk("mid_rst_led", bus.led_out, 8'h00);
    chk("mid_rst_full", bus.at_full, 8'h00);
    chk("mid_rst_off", bus.at_off, 8'hFF);
    rst = 1'b0;
    step();
    chk("rerise_off", bus.at_off, 8'hF7);
    wait_bit(1'b0, 3, 1100, n);
    chk("rerise_lat", n, 1019);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
